// File: rtl/smoldvi_link_ctrl.sv
// smoldvi_link_ctrl
// -----------------
// Brings a DVI/TMDS link up and keeps it up. The gearbox is held in reset,
// released and given time to fill, then the controller waits for the start
// of a frame before letting video through. A reported lane phase error sends
// the link back through reset/settle, up to MAX_RETRIES times, after which
// the controller parks in FAULT until the link is dropped.
//
// Ports
//   clk          rising-edge clock for all logic
//   rst          synchronous, active-high reset
//   en           level, link requested up
//   frame_start  single-cycle pulse at the first pixel of a frame
//   phase_err    single-cycle pulse from the lane checker (slip/corruption)
//   gb_rst_n     active-low reset to the gearbox (both of its domains)
//   ser_en       serializer output enable
//   force_blank  replace video with blanking/control symbols
//   link_up      link trained and passing video
//   fault        retries exhausted
//   retry_count  retrains since the link last left IDLE (saturating)

module smoldvi_link_ctrl #(
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             frame_start,
    input  logic                             phase_err,
    output logic                             gb_rst_n,
    output logic                             ser_en,
    output logic                             force_blank,
    output logic                             link_up,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

    localparam int RW = $clog2(MAX_RETRIES + 1);

    // The counter is loaded with length-1 on entry and the state is left on
    // the cycle it reads zero, so each timed state lasts exactly its length.
    localparam logic [7:0] HOLD_LOAD   = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        SETTLE,
        WAIT_FRAME,
        ACTIVE,
        FAULT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [7:0]      cnt;
    logic [7:0]      next_cnt;
    logic [RW-1:0]   next_retry;

    logic next_gb_rst_n;
    logic next_ser_en;
    logic next_force_blank;
    logic next_link_up;
    logic next_fault;

    // Next-state, counter and retry logic. Dropping en overrides every
    // per-state decision below it; a phase error only counts in WAIT_FRAME
    // and ACTIVE, and beats a coincident frame_start.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_retry = retry_count;

        case (state)
            IDLE: begin
                if (en) begin
                    next_state = HOLD;
                    next_cnt   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    next_state = SETTLE;
                    next_cnt   = SETTLE_LOAD;
                end else begin
                    next_cnt = cnt - 8'd1;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    next_state = WAIT_FRAME;
                end else begin
                    next_cnt = cnt - 8'd1;
                end
            end
            WAIT_FRAME, ACTIVE: begin
                if (phase_err) begin
                    if (retry_count < RETRY_MAX) begin
                        next_retry = retry_count + RW'(1);
                        next_state = HOLD;
                        next_cnt   = HOLD_LOAD;
                    end else begin
                        next_state = FAULT;
                    end
                end else if (state == WAIT_FRAME && frame_start) begin
                    next_state = ACTIVE;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (!en) begin
            next_state = IDLE;
        end

        // retry_count reads zero whenever the FSM sits in IDLE.
        if (next_state == IDLE) begin
            next_retry = '0;
        end
    end

    // Outputs are decoded from the next state and registered alongside the
    // state, so they are flop outputs yet change in the same cycle as state.
    always_comb begin
        next_gb_rst_n    = 1'b0;
        next_ser_en      = 1'b0;
        next_force_blank = 1'b1;
        next_link_up     = 1'b0;
        next_fault       = 1'b0;

        case (next_state)
            SETTLE, WAIT_FRAME: begin
                next_gb_rst_n = 1'b1;
                next_ser_en   = 1'b1;
            end
            ACTIVE: begin
                next_gb_rst_n    = 1'b1;
                next_ser_en      = 1'b1;
                next_force_blank = 1'b0;
                next_link_up     = 1'b1;
            end
            FAULT: begin
                next_fault = 1'b1;
            end
            default: begin
                next_gb_rst_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            retry_count <= '0;
            gb_rst_n    <= 1'b0;
            ser_en      <= 1'b0;
            force_blank <= 1'b1;
            link_up     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            retry_count <= next_retry;
            gb_rst_n    <= next_gb_rst_n;
            ser_en      <= next_ser_en;
            force_blank <= next_force_blank;
            link_up     <= next_link_up;
            fault       <= next_fault;
        end
    end

endmodule

// File: tb/tb_smoldvi_link_ctrl.sv
// Testbench for smoldvi_link_ctrl at default parameters. A table of
// {hold-cycles, inputs, expected outputs} records walks the link through
// bring-up, retrains, fault and drop; a hand-written loop then drives the
// controller into FAULT once more and checks that rst clears it.

module tb_smoldvi_link_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       frame_start;
    logic       phase_err;
    logic       gb_rst_n;
    logic       ser_en;
    logic       force_blank;
    logic       link_up;
    logic       fault;
    logic [1:0] retry_count;

    int n_compared;
    int n_mismatched;

    // Output patterns {gb_rst_n, ser_en, force_blank, link_up, fault}
    localparam logic [4:0] O_IDLE = 5'b00100;   // IDLE and HOLD
    localparam logic [4:0] O_RUN  = 5'b11100;   // SETTLE and WAIT_FRAME
    localparam logic [4:0] O_ACT  = 5'b11010;
    localparam logic [4:0] O_FLT  = 5'b00101;

    typedef struct {
        int         n;
        logic       rst;
        logic       en;
        logic       fs;
        logic       pe;
        logic [4:0] outs;
        logic [1:0] rc;
    } vec_t;

    vec_t vecs[$];

    smoldvi_link_ctrl #(
        .RESET_CYCLES (16),
        .SETTLE_CYCLES(64),
        .MAX_RETRIES  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .frame_start(frame_start),
        .phase_err  (phase_err),
        .gb_rst_n   (gb_rst_n),
        .ser_en     (ser_en),
        .force_blank(force_blank),
        .link_up    (link_up),
        .fault      (fault),
        .retry_count(retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold the given inputs for n rising edges, then sample 1 time unit later.
    task automatic applyStimulus(input int n, input logic r, input logic e,
                                 input logic f, input logic p);
        rst         = r;
        en          = e;
        frame_start = f;
        phase_err   = p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [4:0] outs,
                               input logic [1:0] rc);
        logic [6:0] act;
        logic [6:0] exp;
        act = {gb_rst_n, ser_en, force_blank, link_up, fault, retry_count};
        exp = {outs, rc};
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got {gb,ser,fb,lu,flt,rc}=%b, expected %b",
                     name, act, exp);
        end
    endtask

    task automatic addVec(input int n, input logic r, input logic e,
                          input logic f, input logic p,
                          input logic [4:0] outs, input logic [1:0] rc);
        vec_t v;
        v.n = n; v.rst = r; v.en = e; v.fs = f; v.pe = p;
        v.outs = outs; v.rc = rc;
        vecs.push_back(v);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1; en = 1'b0; frame_start = 1'b0; phase_err = 1'b0;

        // Cycle c = state after c edges since en was first sampled high.
        //      n   rst en fs pe  outputs  rc
        addVec(2,   1, 1, 1, 1,  O_IDLE, 2'd0); // rst dominates everything
        addVec(1,   0, 1, 0, 0,  O_IDLE, 2'd0); // c1 HOLD
        addVec(1,   0, 1, 0, 1,  O_IDLE, 2'd0); // c2 HOLD, phase_err ignored
        addVec(14,  0, 1, 0, 0,  O_IDLE, 2'd0); // c16 last HOLD cycle
        addVec(1,   0, 1, 0, 0,  O_RUN,  2'd0); // c17 SETTLE
        addVec(1,   0, 1, 0, 1,  O_RUN,  2'd0); // c18 SETTLE, phase_err ignored
        addVec(62,  0, 1, 0, 0,  O_RUN,  2'd0); // c80 last SETTLE cycle
        addVec(1,   0, 1, 1, 0,  O_RUN,  2'd0); // frame in SETTLE ignored
        addVec(19,  0, 1, 0, 0,  O_RUN,  2'd0); // c100 WAIT_FRAME
        addVec(1,   0, 1, 1, 0,  O_ACT,  2'd0); // frame at c100 -> ACTIVE c101
        addVec(5,   0, 1, 0, 0,  O_ACT,  2'd0); // stays ACTIVE
        addVec(1,   0, 1, 0, 1,  O_IDLE, 2'd1); // retrain 1 -> HOLD
        addVec(15,  0, 1, 0, 0,  O_IDLE, 2'd1); // 16th HOLD cycle after reload
        addVec(1,   0, 1, 0, 0,  O_RUN,  2'd1); // SETTLE
        addVec(63,  0, 1, 0, 0,  O_RUN,  2'd1); // last SETTLE cycle
        addVec(1,   0, 1, 1, 0,  O_RUN,  2'd1); // 80 cycles later: WAIT_FRAME
        addVec(1,   0, 1, 1, 0,  O_ACT,  2'd1); // frame in 1st WAIT_FRAME cycle
        addVec(1,   0, 1, 0, 1,  O_IDLE, 2'd2); // retrain 2
        addVec(80,  0, 1, 0, 0,  O_RUN,  2'd2); // WAIT_FRAME
        addVec(1,   0, 1, 1, 1,  O_IDLE, 2'd3); // phase_err beats frame_start
        addVec(80,  0, 1, 0, 0,  O_RUN,  2'd3); // WAIT_FRAME
        addVec(1,   0, 1, 0, 1,  O_FLT,  2'd3); // 4th error -> FAULT
        addVec(10,  0, 1, 1, 1,  O_FLT,  2'd3); // FAULT persists
        addVec(1,   0, 0, 0, 0,  O_IDLE, 2'd0); // en=0 -> IDLE, count cleared
        addVec(3,   0, 0, 0, 0,  O_IDLE, 2'd0);
        addVec(1,   0, 1, 0, 0,  O_IDLE, 2'd0); // c1 HOLD
        addVec(16,  0, 1, 0, 0,  O_RUN,  2'd0); // c17 first SETTLE cycle
        addVec(39,  0, 1, 0, 0,  O_RUN,  2'd0); // c56 = 40th SETTLE cycle
        addVec(1,   0, 0, 0, 0,  O_IDLE, 2'd0); // en dropped -> IDLE
        addVec(1,   0, 1, 0, 0,  O_IDLE, 2'd0); // c1 HOLD again
        addVec(15,  0, 1, 0, 0,  O_IDLE, 2'd0); // c16 still HOLD (full length)
        addVec(1,   0, 1, 0, 0,  O_RUN,  2'd0); // c17 SETTLE
        addVec(63,  0, 1, 0, 0,  O_RUN,  2'd0); // c80
        addVec(1,   0, 1, 1, 0,  O_RUN,  2'd0); // c81 WAIT_FRAME
        addVec(1,   0, 1, 1, 0,  O_ACT,  2'd0); // c82 ACTIVE
        addVec(1,   0, 1, 0, 1,  O_IDLE, 2'd1); // retrain
        addVec(80,  0, 1, 0, 0,  O_RUN,  2'd1);
        addVec(1,   0, 1, 1, 0,  O_ACT,  2'd1);
        addVec(1,   0, 0, 0, 1,  O_IDLE, 2'd0); // en=0 beats phase_err
        addVec(1,   0, 1, 0, 0,  O_IDLE, 2'd0); // HOLD
        addVec(80,  0, 1, 0, 0,  O_RUN,  2'd0);
        addVec(1,   0, 1, 1, 0,  O_ACT,  2'd0);
        addVec(1,   1, 1, 0, 0,  O_IDLE, 2'd0); // rst in ACTIVE
        addVec(1,   0, 1, 0, 0,  O_IDLE, 2'd0); // HOLD from clean IDLE
        addVec(1,   0, 0, 0, 0,  O_IDLE, 2'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].n, vecs[i].rst, vecs[i].en,
                          vecs[i].fs, vecs[i].pe);
            checkOutput($sformatf("vec%0d", i), vecs[i].outs, vecs[i].rc);
        end

        // Drive into FAULT by retraining from each WAIT_FRAME, then rst out.
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(80, 1'b0, 1'b1, 1'b0, 1'b0);
            applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b1);
            if (k < 3)
                checkOutput($sformatf("retrain%0d", k + 1), O_IDLE, 2'(k + 1));
            else
                checkOutput("fault_entry", O_FLT, 2'd3);
        end
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_in_fault", O_IDLE, 2'd0);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_after_rst", O_IDLE, 2'd0);
        applyStimulus(16, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("settle_after_rst", O_RUN, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
